i2c_byte_engine: RTL and testbench

I2C_BYTE_ENGINE -- requirements
Module: i2c_byte_engine

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_qtr_timer.sv | 45 ++++
 rtl/i2c_byte_engine.sv | 147 ++++++++++++++
 tb/tb_i2c_byte_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: the command encoding the MCU uses, the engine state set,
// and the default quarter-period divider.
package i2c_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_STOP  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

  localparam int CLK_DIV_DEFAULT = 30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_BIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/i2c_qtr_timer.sv
// SCL quarter-period timer: counts CLK_DIV cycles per quarter and steps the quarter index.
// With I2C_CLK_STRETCH_EN defined, a released-but-low SCL holds the count (clock stretching).
module i2c_qtr_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       run,
  input  logic       scl_rel,
  input  logic       scl_in,
  output logic       tick,
  output logic [1:0] qidx
);

  logic [7:0] cnt;
  logic       hold;

`ifdef I2C_CLK_STRETCH_EN
  assign hold = scl_rel && !scl_in;
`else
  logic unused_stretch;
  assign unused_stretch = scl_rel ^ scl_in;
  assign hold = 1'b0;
`endif

  assign tick = run && !hold && (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt  <= '0;
      qidx <= '0;
    end else if (!run) begin
      cnt  <= '0;
      qidx <= '0;
    end else if (tick) begin
      cnt  <= '0;
      qidx <= qidx + 2'd1;
    end else if (!hold) begin
      cnt  <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/i2c_byte_engine.sv
// I2C master byte engine: executes START, STOP, WRITE and READ commands from the MCU,
// driving open-drain SCL/SDA enables. Optional clock stretching via I2C_CLK_STRETCH_EN.
module i2c_byte_engine
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_nack,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       ack_rcvd,
  output logic       cmd_err,
  output logic       bus_active,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  state_t     state, state_nx;
  logic [1:0] cmd_q;
  logic [7:0] wr_q;
  logic       nack_q;
  logic [3:0] bitcnt;
  logic [7:0] rx_sh;
  logic       ack_s;
  logic       tick;
  logic [1:0] qidx;
  logic       run;
  logic       accept;
  logic       last_bit;
  logic       bit_sda;

  assign accept   = cmd_valid && cmd_ready;
  assign last_bit = (bitcnt == 4'd8);
  // An illegal byte command passes through BIT for one cycle without touching the bus.
  assign run      = (state == ST_START) || (state == ST_STOP) || ((state == ST_BIT) && bus_active);

  i2c_qtr_timer #(.CLK_DIV(CLK_DIV)) u_qtr (
    .clk    (clk),
    .nReset (nReset),
    .run    (run),
    .scl_rel(run && !scl_oe),
    .scl_in (scl_in),
    .tick   (tick),
    .qidx   (qidx)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    scl_oe    = bus_active;
    sda_oe    = 1'b0;
    if (cmd_q == CMD_WRITE) bit_sda = last_bit ? 1'b0 : ~wr_q[~bitcnt[2:0]];
    else                    bit_sda = last_bit ? ~nack_q : 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (accept) begin
          case (cmd)
            CMD_START: state_nx = ST_START;
            CMD_STOP:  state_nx = ST_STOP;
            default:   state_nx = ST_BIT;
          endcase
        end
      end
      ST_START: begin
        scl_oe = (qidx == 2'd0) || (qidx == 2'd3);
        sda_oe = qidx[1];
        if (tick && qidx == 2'd3) state_nx = ST_DONE;
      end
      ST_STOP: begin
        scl_oe = (qidx == 2'd0);
        sda_oe = (qidx != 2'd3);
        if (tick && qidx == 2'd3) state_nx = ST_DONE;
      end
      ST_BIT: begin
        if (!bus_active) begin
          scl_oe   = 1'b0;
          state_nx = ST_DONE;
        end else begin
          scl_oe = (qidx == 2'd0) || (qidx == 2'd3);
          sda_oe = bit_sda;
          if (tick && qidx == 2'd3 && last_bit) state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cmd_q      <= CMD_START;
      wr_q       <= '0;
      nack_q     <= 1'b0;
      bitcnt     <= '0;
      rx_sh      <= '0;
      ack_s      <= 1'b0;
      rd_data    <= '0;
      ack_rcvd   <= 1'b0;
      cmd_err    <= 1'b0;
      bus_active <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q  <= cmd;
        wr_q   <= wr_data;
        nack_q <= rd_nack;
      end
      if (run && state == ST_BIT) begin
        if (tick && qidx == 2'd3) bitcnt <= bitcnt + 4'd1;
        // SDA is sampled on the last cycle of the SCL-high quarter.
        if (tick && qidx == 2'd2) begin
          if (last_bit) ack_s <= ~sda_in;
          else          rx_sh <= {rx_sh[6:0], sda_in};
        end
      end else begin
        bitcnt <= '0;
      end
      if (state_nx == ST_DONE && state != ST_DONE) begin
        cmd_err <= (state == ST_BIT) && !bus_active;
        if (state == ST_START) bus_active <= 1'b1;
        if (state == ST_STOP)  bus_active <= 1'b0;
        if (state == ST_BIT && bus_active) begin
          if (cmd_q == CMD_READ) rd_data  <= rx_sh;
          else                   ack_rcvd <= ack_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Directed bench for i2c_byte_engine (CLK_DIV=4) with a small open-drain slave model.
// Define I2C_CLK_STRETCH_EN to also run the clock-stretch step.
module tb_i2c_byte_engine;
  import i2c_pkg::*;

  localparam int D = 4;

  logic       clk, nReset, cmd_valid, cmd_ready, rd_nack, rsp_valid;
  logic       ack_rcvd, cmd_err, bus_active, scl_oe, sda_oe, scl_in, sda_in;
  logic [1:0] cmd;
  logic [7:0] wr_data, rd_data;

  int nvec = 0;
  int nerr = 0;

  int mode = 0;
  int bitn = 0;
  int slv_idx = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int hold_left = 0;
  logic [7:0]  rd_byte = 8'h00;
  logic        stretch_hold = 1'b0;
  logic        stretch_arm = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic [15:0] rise_log = '0;
  logic [15:0] mst_log = '0;
  logic        scl_line, sda_line, slave_sda;

  assign slave_sda = (mode == 1 && slv_idx == 8) ||
                     (mode == 2 && slv_idx < 8 && !rd_byte[3'(7 - slv_idx)]);
  assign scl_line  = ~scl_oe & ~stretch_hold;
  assign sda_line  = ~sda_oe & ~slave_sda;
  assign scl_in    = scl_line;
  assign sda_in    = sda_line;

  i2c_byte_engine #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .wr_data   (wr_data),
    .rd_nack   (rd_nack),
    .rsp_valid (rsp_valid),
    .rd_data   (rd_data),
    .ack_rcvd  (ack_rcvd),
    .cmd_err   (cmd_err),
    .bus_active(bus_active),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .scl_in    (scl_in),
    .sda_in    (sda_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave holds SCL low for 20 cycles once the master releases it in bit 2.
  always @(posedge clk) begin
    #1;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) stretch_hold = 1'b0;
    end else if (stretch_arm && slv_idx == 2 && !scl_oe) begin
      stretch_arm  = 1'b0;
      stretch_hold = 1'b1;
      hold_left    = 20;
    end
  end

  // Bus monitor and slave bit tracker.
  always @(posedge clk) begin
    #2;
    if (scl_line && !prev_scl) begin
      bitn++;
      rise_log = {rise_log[14:0], sda_line};
      mst_log  = {mst_log[14:0], sda_oe};
    end
    if (scl_line && prev_scl && sda_line != prev_sda) begin
      if (!sda_line) begin
        start_cnt++;
        bitn    = 0;
        slv_idx = 0;
      end else begin
        stop_cnt++;
      end
    end
    if (!scl_line && prev_scl) slv_idx = bitn % 9;
    prev_scl = scl_line;
    prev_sda = sda_line;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d, input logic n);
    int w;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", 32'(cmd_ready), 32'd1);
    cmd = c; wr_data = d; rd_nack = n; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wr_data   = ~d;
    rd_nack   = ~n;
  endtask

  task automatic wait_rsp(output int lat, output logic oe_seen);
    lat = 0;
    oe_seen = 1'b0;
    @(negedge clk);
    lat = 1;
    check("ready_drop", 32'(cmd_ready), 32'd0);
    while (!rsp_valid && lat < 3000) begin
      oe_seen |= scl_oe | sda_oe;
      @(negedge clk);
      lat++;
    end
    oe_seen |= scl_oe | sda_oe;
    check("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    int   lat;
    int   w;
    logic oe;
    logic seen;

    nReset = 1'b1; cmd_valid = 1'b0; cmd = CMD_START; wr_data = 8'h00; rd_nack = 1'b0;
    #1 nReset = 1'b0;
    #1;
    check("rst_ready",  32'(cmd_ready),  32'd1);
    check("rst_scl",    32'(scl_oe),     32'd0);
    check("rst_sda",    32'(sda_oe),     32'd0);
    check("rst_rsp",    32'(rsp_valid),  32'd0);
    check("rst_rdata",  32'(rd_data),    32'h00);
    check("rst_ack",    32'(ack_rcvd),   32'd0);
    check("rst_err",    32'(cmd_err),    32'd0);
    check("rst_active", 32'(bus_active), 32'd0);
    repeat (2) @(negedge clk);
    nReset = 1'b1;

    // WRITE with the bus idle is illegal
    send(CMD_WRITE, 8'h55, 1'b0);
    wait_rsp(lat, oe);
    check("err_lat",    32'(lat),        32'd2);
    check("err_flag",   32'(cmd_err),    32'd1);
    check("err_ack",    32'(ack_rcvd),   32'd0);
    check("err_active", 32'(bus_active), 32'd0);
    check("err_no_oe",  32'(oe),         32'd0);

    // START from idle
    send(CMD_START, 8'h00, 1'b0);
    wait_rsp(lat, oe);
    check("start_lat",    32'(lat),        32'd17);
    check("start_active", 32'(bus_active), 32'd1);
    check("start_err",    32'(cmd_err),    32'd0);
    check("start_cond",   32'(start_cnt),  32'd1);
    @(negedge clk);
    check("start_scl_held", 32'(scl_oe), 32'd1);

    // WRITE 0xA5, slave ACKs
    mode = 1;
    send(CMD_WRITE, 8'hA5, 1'b0);
    wait_rsp(lat, oe);
    check("wr_lat",  32'(lat),           32'd145);
    check("wr_ack",  32'(ack_rcvd),      32'd1);
    check("wr_err",  32'(cmd_err),       32'd0);
    check("wr_bits", 32'(rise_log[8:0]), 32'({8'hA5, 1'b0}));

    // READ 0x3C with NACK
    mode = 2; rd_byte = 8'h3C;
    send(CMD_READ, 8'h00, 1'b1);
    wait_rsp(lat, oe);
    check("rd_lat",     32'(lat),           32'd145);
    check("rd_data",    32'(rd_data),       32'h3C);
    check("rd_ack_old", 32'(ack_rcvd),      32'd1);
    check("rd_bits",    32'(rise_log[8:0]), 32'({8'h3C, 1'b1}));
    check("rd_mst_rel", 32'(mst_log[8:0]),  32'd0);
    mode = 0;

    // Repeated START while the bus is held
    send(CMD_START, 8'h00, 1'b0);
    wait_rsp(lat, oe);
    check("rstart_lat",  32'(lat),       32'd17);
    check("rstart_cond", 32'(start_cnt), 32'd2);

    // STOP
    send(CMD_STOP, 8'h00, 1'b0);
    wait_rsp(lat, oe);
    check("stop_lat",    32'(lat),        32'd17);
    check("stop_active", 32'(bus_active), 32'd0);
    check("stop_cond",   32'(stop_cnt),   32'd1);
    check("stop_rdata",  32'(rd_data),    32'h3C);
    check("stop_err",    32'(cmd_err),    32'd0);
    @(negedge clk);
    check("stop_lines", 32'({scl_oe, sda_oe}), 32'd0);
    check("no_stray_start", 32'(start_cnt), 32'd2);

    // STOP with the bus already idle still produces a STOP condition
    send(CMD_STOP, 8'h00, 1'b0);
    wait_rsp(lat, oe);
    check("stop2_lat",  32'(lat),      32'd17);
    check("stop2_cond", 32'(stop_cnt), 32'd2);

`ifdef I2C_CLK_STRETCH_EN
    send(CMD_START, 8'h00, 1'b0);
    wait_rsp(lat, oe);
    mode = 1; stretch_arm = 1'b1;
    send(CMD_WRITE, 8'h5A, 1'b0);
    wait_rsp(lat, oe);
    check("str_lat",  32'(lat),           32'd165);
    check("str_ack",  32'(ack_rcvd),      32'd1);
    check("str_bits", 32'(rise_log[8:0]), 32'({8'h5A, 1'b0}));
    mode = 0;
    send(CMD_STOP, 8'h00, 1'b0);
    wait_rsp(lat, oe);
`endif

    // Reset in the middle of WRITE bit 4
    send(CMD_START, 8'h00, 1'b0);
    wait_rsp(lat, oe);
    send(CMD_WRITE, 8'hF0, 1'b0);
    w = 0;
    while (slv_idx != 4 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("reach_bit4", 32'(slv_idx), 32'd4);
    repeat (D + 2) @(negedge clk);
    check("bit4_scl", 32'(scl_oe), 32'd1);
    check("bit4_sda", 32'(sda_oe), 32'd1);
    #1 nReset = 1'b0;
    #1;
    check("arst_lines",  32'({scl_oe, sda_oe}), 32'd0);
    check("arst_ready",  32'(cmd_ready),        32'd1);
    check("arst_active", 32'(bus_active),       32'd0);
    seen = 1'b0;
    repeat (3) begin
      seen |= rsp_valid;
      @(negedge clk);
    end
    check("arst_no_rsp", 32'(seen), 32'd0);
    nReset = 1'b1;
    check("post_ready", 32'(cmd_ready), 32'd1);
    check("post_rdata", 32'(rd_data),   32'h00);
    check("post_ack",   32'(ack_rcvd),  32'd0);

    // First edge after reset release accepts a command
    send(CMD_START, 8'h00, 1'b0);
    wait_rsp(lat, oe);
    check("post_start_lat", 32'(lat), 32'd17);
    send(CMD_STOP, 8'h00, 1'b0);
    wait_rsp(lat, oe);
    check("post_stop_active", 32'(bus_active), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
